id_ex_stage: RTL and testbench

- ID/EX pipeline register for the 5-stage core; consumes the register file read ports and the decode outputs, and registers them for EX.
- Adds a WB->ID write-through bypass. The register file writes on posedge and reads combinationally, so a same-cycle WB write is otherwise missed.
- Contains load-use hazard detection (bubble insertion plus upstream stall), branch flush, downstream hold, and a bubble counter.

---
 rtl/pipeline_pkg.sv | 10 +
 rtl/id_ex_stage_load_use_detect.sv | 16 +
 rtl/id_ex_stage.sv | 93 +++++++++
 tb/tb_id_ex_stage.sv | 191 +++++++++++++++++++
 4 files changed

// File: rtl/pipeline_pkg.sv
// pipeline_pkg: shared widths and bubble constants for the 5-stage core
package pipeline_pkg;
    localparam int XLEN      = 32;
    localparam int CTRL_W    = 8;
    localparam int REG_IDX_W = 5;
    localparam int CTRL_NOP  = 0;
    localparam logic BUBBLE_VALID     = 1'b0;
    localparam logic BUBBLE_MEM_READ  = 1'b0;
    localparam logic BUBBLE_REG_WRITE = 1'b0;
endpackage

// File: rtl/id_ex_stage_load_use_detect.sv
// load_use_detect: flags an ID instruction reading the destination of a load sitting in EX
module load_use_detect
    import pipeline_pkg::*;
(
    input  logic                 ex_valid,
    input  logic                 ex_mem_read,
    input  logic [REG_IDX_W-1:0] ex_rd,
    input  logic                 id_valid,
    input  logic [REG_IDX_W-1:0] id_rs1,
    input  logic [REG_IDX_W-1:0] id_rs2,
    output logic                 load_use
);
    // rs2 is always compared, even for formats that do not read it
    assign load_use = ex_valid && ex_mem_read && ex_rd != '0 && id_valid &&
                      (ex_rd == id_rs1 || ex_rd == id_rs2);
endmodule

// File: rtl/id_ex_stage.sv
// id_ex_stage: ID/EX pipeline register with WB write-through bypass and load-use bubbling
module id_ex_stage
    import pipeline_pkg::*;
#(
    parameter int XLEN   = pipeline_pkg::XLEN,
    parameter int CTRL_W = pipeline_pkg::CTRL_W
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 id_valid,
    input  logic [XLEN-1:0]      id_pc,
    input  logic [REG_IDX_W-1:0] id_rs1,
    input  logic [REG_IDX_W-1:0] id_rs2,
    input  logic [REG_IDX_W-1:0] id_rd,
    input  logic [XLEN-1:0]      id_imm,
    input  logic [CTRL_W-1:0]    id_ctrl,
    input  logic                 id_mem_read,
    input  logic                 id_reg_write,
    input  logic [XLEN-1:0]      rf_read_data1,
    input  logic [XLEN-1:0]      rf_read_data2,
    input  logic                 wb_reg_write,
    input  logic [REG_IDX_W-1:0] wb_write_reg,
    input  logic [XLEN-1:0]      wb_write_data,
    input  logic                 flush,
    input  logic                 hold,
    output logic                 stall_if_id,
    output logic                 ex_valid,
    output logic                 ex_mem_read,
    output logic                 ex_reg_write,
    output logic [XLEN-1:0]      ex_pc,
    output logic [XLEN-1:0]      ex_imm,
    output logic [XLEN-1:0]      ex_rs1_data,
    output logic [XLEN-1:0]      ex_rs2_data,
    output logic [REG_IDX_W-1:0] ex_rs1,
    output logic [REG_IDX_W-1:0] ex_rs2,
    output logic [REG_IDX_W-1:0] ex_rd,
    output logic [CTRL_W-1:0]    ex_ctrl,
    output logic [31:0]          bubble_count
);
    logic            load_use;
    logic [XLEN-1:0] rs1_data;
    logic [XLEN-1:0] rs2_data;

    load_use_detect u_lud (
        .ex_valid   (ex_valid),
        .ex_mem_read(ex_mem_read),
        .ex_rd      (ex_rd),
        .id_valid   (id_valid),
        .id_rs1     (id_rs1),
        .id_rs2     (id_rs2),
        .load_use   (load_use)
    );

    // the register file reads before its posedge write lands, so forward WB data here
    assign rs1_data = (id_rs1 == '0) ? '0 :
                      (wb_reg_write && wb_write_reg == id_rs1) ? wb_write_data : rf_read_data1;
    assign rs2_data = (id_rs2 == '0) ? '0 :
                      (wb_reg_write && wb_write_reg == id_rs2) ? wb_write_data : rf_read_data2;

    assign stall_if_id = hold || (load_use && !flush);

    always_ff @(posedge clk) begin
        if (rst || flush || (!hold && load_use)) begin
            ex_valid     <= BUBBLE_VALID;
            ex_mem_read  <= BUBBLE_MEM_READ;
            ex_reg_write <= BUBBLE_REG_WRITE;
            ex_ctrl      <= CTRL_W'(CTRL_NOP);
            ex_pc        <= '0;
            ex_imm       <= '0;
            ex_rs1_data  <= '0;
            ex_rs2_data  <= '0;
            ex_rs1       <= '0;
            ex_rs2       <= '0;
            ex_rd        <= '0;
        end else if (!hold) begin
            ex_valid     <= id_valid;
            ex_mem_read  <= id_valid && id_mem_read;
            ex_reg_write <= id_valid && id_reg_write;
            ex_ctrl      <= id_ctrl;
            ex_pc        <= id_pc;
            ex_imm       <= id_imm;
            ex_rs1_data  <= rs1_data;
            ex_rs2_data  <= rs2_data;
            ex_rs1       <= id_rs1;
            ex_rs2       <= id_rs2;
            ex_rd        <= id_rd;
        end
        if (rst)
            bubble_count <= '0;
        else if (!flush && !hold && load_use)
            bubble_count <= bubble_count + 32'd1;
    end
endmodule

// File: tb/tb_id_ex_stage.sv
// tb_id_ex_stage: directed plus random checks of id_ex_stage against a cycle-level reference model
module tb_id_ex_stage;
    import pipeline_pkg::*;
    localparam int XL = 32;
    localparam int CW = 8;
    logic clk = 1'b0;
    always #5 clk = ~clk;
    logic          rst, id_valid, id_mem_read, id_reg_write, wb_reg_write, flush, hold;
    logic [XL-1:0] id_pc, id_imm, rf_read_data1, rf_read_data2, wb_write_data;
    logic [4:0]    id_rs1, id_rs2, id_rd, wb_write_reg;
    logic [CW-1:0] id_ctrl;
    logic          stall_if_id, ex_valid, ex_mem_read, ex_reg_write;
    logic [XL-1:0] ex_pc, ex_imm, ex_rs1_data, ex_rs2_data;
    logic [4:0]    ex_rs1, ex_rs2, ex_rd;
    logic [CW-1:0] ex_ctrl;
    logic [31:0]   bubble_count;
    logic [XL-1:0] rf [32];
    int n_tests = 0;
    int n_fail = 0;
    // expected architectural state of the EX slot
    logic          m_valid, m_mr, m_rw, m_known;
    logic [XL-1:0] m_pc, m_imm, m_d1, m_d2;
    logic [4:0]    m_rs1, m_rs2, m_rd;
    logic [CW-1:0] m_ctrl;
    logic [31:0]   m_cnt;

    id_ex_stage #(.XLEN(XL), .CTRL_W(CW)) dut (
        .clk(clk), .rst(rst), .id_valid(id_valid), .id_pc(id_pc), .id_rs1(id_rs1),
        .id_rs2(id_rs2), .id_rd(id_rd), .id_imm(id_imm), .id_ctrl(id_ctrl),
        .id_mem_read(id_mem_read), .id_reg_write(id_reg_write),
        .rf_read_data1(rf_read_data1), .rf_read_data2(rf_read_data2),
        .wb_reg_write(wb_reg_write), .wb_write_reg(wb_write_reg), .wb_write_data(wb_write_data),
        .flush(flush), .hold(hold), .stall_if_id(stall_if_id), .ex_valid(ex_valid),
        .ex_mem_read(ex_mem_read), .ex_reg_write(ex_reg_write), .ex_pc(ex_pc), .ex_imm(ex_imm),
        .ex_rs1_data(ex_rs1_data), .ex_rs2_data(ex_rs2_data), .ex_rs1(ex_rs1), .ex_rs2(ex_rs2),
        .ex_rd(ex_rd), .ex_ctrl(ex_ctrl), .bubble_count(bubble_count)
    );

    assign rf_read_data1 = rf[id_rs1];
    assign rf_read_data2 = rf[id_rs2];
    always @(posedge clk) if (wb_reg_write) rf[wb_write_reg] <= wb_write_data;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // value register r holds once this cycle's writeback has landed; x0 reads as zero
    function automatic logic [XL-1:0] arch_reg(input logic [4:0] r);
        if (r == 5'd0) return '0;
        if (wb_reg_write && wb_write_reg == r) return wb_write_data;
        return rf[r];
    endfunction

    task automatic idle();
        {rst, id_valid, id_mem_read, id_reg_write, wb_reg_write, flush, hold} = '0;
        {id_pc, id_imm, wb_write_data} = '0;
        {id_rs1, id_rs2, id_rd, wb_write_reg} = '0;
        id_ctrl = '0;
    endtask

    task automatic step();
        logic lu;
        @(negedge clk);
        lu = m_valid && m_mr && m_rd != 0 && id_valid && (m_rd == id_rs1 || m_rd == id_rs2);
        chk("stall_if_id", stall_if_id, hold || (lu && !flush));
        if (rst) begin
            {m_valid, m_mr, m_rw, m_pc, m_imm, m_d1, m_d2, m_rs1, m_rs2, m_rd, m_ctrl} = '0;
            m_cnt = 0;
            m_known = 1'b1;
        end else if (flush || (!hold && lu)) begin
            {m_valid, m_mr, m_rw, m_ctrl} = '0;
            m_known = 1'b0;
            if (!flush) m_cnt++;
        end else if (!hold) begin
            m_valid = id_valid;
            m_mr = id_valid && id_mem_read;
            m_rw = id_valid && id_reg_write;
            m_pc = id_pc; m_imm = id_imm; m_ctrl = id_ctrl;
            m_d1 = arch_reg(id_rs1); m_d2 = arch_reg(id_rs2);
            m_rs1 = id_rs1; m_rs2 = id_rs2; m_rd = id_rd;
            m_known = 1'b1;
        end
        @(posedge clk);
        #1;
        chk("ex_valid", ex_valid, m_valid);
        chk("ex_mem_read", ex_mem_read, m_mr);
        chk("ex_reg_write", ex_reg_write, m_rw);
        chk("ex_ctrl", ex_ctrl, m_ctrl);
        chk("bubble_count", bubble_count, m_cnt);
        if (m_known) begin
            chk("ex_pc", ex_pc, m_pc);
            chk("ex_imm", ex_imm, m_imm);
            chk("ex_rs1_data", ex_rs1_data, m_d1);
            chk("ex_rs2_data", ex_rs2_data, m_d2);
            chk("ex_rs1", ex_rs1, m_rs1);
            chk("ex_rs2", ex_rs2, m_rs2);
            chk("ex_rd", ex_rd, m_rd);
        end
    endtask

    task automatic rand_instr();
        id_valid = ($urandom_range(0, 9) != 0);
        id_pc = $urandom; id_imm = $urandom; id_ctrl = CW'($urandom);
        id_rs1 = 5'($urandom_range(0, 7));
        id_rs2 = 5'($urandom_range(0, 7));
        id_rd = 5'($urandom_range(0, 7));
        id_mem_read = ($urandom_range(0, 2) == 0);
        id_reg_write = $urandom_range(0, 1) == 1;
    endtask

    initial begin
        for (int i = 0; i < 32; i++) rf[i] = $urandom;
        idle();
        m_known = 1'b0;
        {m_valid, m_mr, m_rw, m_ctrl, m_cnt} = '0;
        rst = 1'b1;
        step();
        chk("reset_ex_valid", ex_valid, 1'b0);
        chk("reset_bubble_count", bubble_count, 32'd0);
        rst = 1'b0;
        // basic load of rs1 from the register file
        rf[3] = 32'h55;
        id_valid = 1'b1; id_rs1 = 5'd3; id_rd = 5'd7; id_pc = 32'h100;
        step();
        chk("basic_rs1_data", ex_rs1_data, 32'h55);
        chk("basic_rd", ex_rd, 5'd7);
        // WB write-through bypass, then x0 stays zero
        rf[5] = 32'h1;
        wb_reg_write = 1'b1; wb_write_reg = 5'd5; wb_write_data = 32'hDEAD; id_rs2 = 5'd5;
        step();
        chk("bypass_rs2_data", ex_rs2_data, 32'hDEAD);
        wb_write_reg = 5'd0; id_rs2 = 5'd0;
        step();
        chk("x0_rs2_data", ex_rs2_data, 32'h0);
        wb_reg_write = 1'b0;
        // load into x4 followed by a user of x4
        id_mem_read = 1'b1; id_rd = 5'd4; id_rs1 = 5'd1; id_rs2 = 5'd2;
        step();
        id_mem_read = 1'b0; id_rd = 5'd9; id_rs1 = 5'd4;
        step();
        chk("lu_bubble_valid", ex_valid, 1'b0);
        chk("lu_bubble_count", bubble_count, 32'd1);
        step();
        chk("lu_resume_valid", ex_valid, 1'b1);
        // load to x0 never stalls
        id_mem_read = 1'b1; id_rd = 5'd0;
        step();
        id_mem_read = 1'b0; id_rs1 = 5'd0; id_rs2 = 5'd0;
        step();
        chk("x0_load_count", bubble_count, 32'd1);
        // flush together with a load-use hazard
        id_mem_read = 1'b1; id_rd = 5'd6;
        step();
        id_mem_read = 1'b0; id_rs1 = 5'd6; flush = 1'b1;
        step();
        chk("flush_lu_count", bubble_count, 32'd1);
        flush = 1'b0;
        // hold for three cycles with changing ID inputs, release, then reset mid-hold
        hold = 1'b1;
        for (int i = 0; i < 3; i++) begin
            rand_instr();
            step();
        end
        hold = 1'b0;
        rand_instr();
        step();
        hold = 1'b1;
        rand_instr();
        step();
        rst = 1'b1;
        step();
        chk("rst_hold_pc", ex_pc, 32'h0);
        rst = 1'b0; hold = 1'b0;
        for (int c = 0; c < 3000; c++) begin
            rand_instr();
            rst = ($urandom_range(0, 59) == 0);
            flush = ($urandom_range(0, 9) == 0);
            hold = ($urandom_range(0, 5) == 0);
            wb_reg_write = $urandom_range(0, 1) == 1;
            wb_write_reg = 5'($urandom_range(0, 7));
            wb_write_data = $urandom;
            step();
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
